uart_stream_rx: RTL
===================

UART_STREAM_RX -- requirements
Module: uart_stream_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 16000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 57600, serial bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, 2..16.
REQ-004 The block SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 The block SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port o_tdata  output  8  received byte, stream data.
REQ-008 The block SHALL have port o_tlast  output  1  end-of-message marker for o_tdata.
REQ-009 The block SHALL have port o_tvalid  output  1  stream valid.
REQ-010 The block SHALL have port i_tready  input  1  downstream ready.
REQ-011 The block SHALL have port o_overrun  output  1  sticky flag: a byte was dropped on a full FIFO.
REQ-012 The block SHALL have port o_frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-013 DIV SHALL equal CLK_FREQ_HZ/BAUD_RATE with integer truncation; elaboration SHALL fail if DIV < 8.
REQ-014 i_uart_rx SHALL pass a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: line==0 -> START, bit counter cleared, baud counter loaded.
REQ-017 START: after DIV/2 cycles, resample the line; 0 -> DATA; 1 -> IDLE (glitch rejected, nothing pushed).
REQ-018 DATA: sample every DIV cycles, 8 bits, LSB first, into a shift register; after bit 7 -> STOP.
REQ-019 STOP: sample after DIV cycles; 1 -> push the byte, go to IDLE; 0 -> pulse o_frame_err, discard the byte, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: stay until line==1, then go to IDLE.
REQ-021 The push SHALL write the FIFO on the cycle after the stop-bit sample; with the FIFO empty, o_tvalid SHALL be high on the next cycle.
REQ-022 A transfer SHALL occur when o_tvalid && i_tready; o_tdata/o_tlast SHALL be stable while o_tvalid && !i_tready.
REQ-023 o_tvalid SHALL equal FIFO not-empty; there is no combinational path from i_tready to o_tvalid.
REQ-024 Simultaneous push and pop SHALL both occur at any fill level, including full; occupancy is unchanged.
REQ-025 A push with the FIFO full and no pop in the same cycle SHALL drop the new byte and set o_overrun; FIFO contents are unchanged.
REQ-026 o_overrun SHALL remain set until i_rst.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-028 The receiver SHALL accept back-to-back frames with a stop bit of exactly one bit time.

Reset
REQ-029 On i_rst: FSM=IDLE, FIFO empty, o_tvalid=0, o_tdata=0, o_tlast=0, o_overrun=0, o_frame_err=0, synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no push; after release, the next falling edge SHALL start a fresh frame.
REQ-031 A frame whose start bit began during reset SHALL NOT be received; if the line is low at release, the FSM SHALL enter START from IDLE and reject or receive normally per REQ-017.

Configuration
REQ-032 Macro UART_STREAM_RX_NEWLINE_TLAST_EN defined: each FIFO entry SHALL store tlast = (byte == 8'h0A), presented on o_tlast with its byte.
REQ-033 Macro undefined: o_tlast SHALL be tied to 0, and the FIFO SHALL store 8 bits per entry.

Verification (CLK_FREQ_HZ=921600, BAUD_RATE=57600, DIV=16, FIFO_DEPTH=4)
REQ-034 Frame 0x55, i_tready=1 -> one beat, o_tdata=0x55, o_tvalid high 1 cycle after the stop sample, o_frame_err=0.
REQ-035 0-level glitch of 4 cycles on an idle line -> no beat, FSM returns to IDLE, o_frame_err=0.
REQ-036 Frame 0xA3 with stop bit forced 0, then line high, then frame 0x11 -> one o_frame_err pulse, single beat 0x11.
REQ-037 i_tready=0, six back-to-back frames 0x01..0x06 -> o_overrun=1; draining yields 0x01..0x04 in order, then o_tvalid=0.
REQ-038 Frames 0x48 0x0A with the macro defined -> o_tlast 0 then 1; with the macro undefined -> o_tlast 0 on both.
REQ-039 i_rst pulsed during bit 3 of frame 0x7E, then frame 0x3C -> only 0x3C delivered, all flags 0.

Source files
------------

// File: rtl/uart_stream_rx.sv
// UART 8N1 receiver feeding a small AXI-Stream style output FIFO.
// Optional: define UART_STREAM_RX_NEWLINE_TLAST_EN to mark 8'h0A bytes with tlast.
module uart_stream_rx #(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD_RATE   = 57600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_overrun,
  output logic       o_frame_err
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef UART_STREAM_RX_NEWLINE_TLAST_EN
  localparam int EW  = 9;
`else
  localparam int EW  = 8;
`endif

  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  if (DIV < 8) begin : g_bad_div
    $error("uart_stream_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_stream_rx: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  logic sync1_q, sync2_q, line;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, giving a true two-stage chain.
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!line) begin
          state_d = START;
          cnt_d   = CNT_HALF;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (!line) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (line) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_frame_err = frame_err_q;

  // Output FIFO: extra pointer bit separates full from empty.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          empty, full, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && i_tready;
  assign wr_en = push_q && (!full || pop);

`ifdef UART_STREAM_RX_NEWLINE_TLAST_EN
  assign wr_entry = {(shift_q == 8'h0A), shift_q};
`else
  assign wr_entry = shift_q;
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (push_q && full && !pop) o_overrun <= 1'b1;
    end
  end

  // Outputs are forced to zero while empty so reset state is defined without clearing storage.
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];
  assign o_tvalid = !empty;
  assign o_tdata  = empty ? 8'h00 : rd_entry[7:0];
`ifdef UART_STREAM_RX_NEWLINE_TLAST_EN
  assign o_tlast  = !empty && rd_entry[8];
`else
  assign o_tlast  = 1'b0;
`endif

endmodule
